// File: rtl/kda_client_echo_node.sv
// kda_client_echo_node
//   Client-side responder for KDA ring test traffic. It accepts request
//   packets and transforms each one on enqueue: byte 0 (the sequence number)
//   is echoed, and every other byte is incremented mod 256 with no carry
//   between bytes. Each transformed packet is buffered in a small FIFO and
//   returned. The node counts round trips and raises a sticky done once
//   iterations_p responses have been consumed.
//
//   Optional feature macro: KDA_CLIENT_SEQ_CHECK_EN
//     When defined, byte 0 of each request is checked against an expected
//     sequence number, and a mismatch sets the sticky err_o.
//     When undefined, err_o is tied low.
//
// Ports
//   clk_i            core clock
//   async_reset_n_i  asynchronous active-low reset
//   en_i             node enable
//   v_i / data_i     request valid / packet (byte 0 = sequence number)
//   ready_o          request accept (transfer on v_i & ready_o)
//   v_o / data_o     response valid / head-of-FIFO packet
//   yumi_i           response consumed (ignored when v_o = 0)
//   done_o           sticky completion
//   err_o            sticky sequence error
//   rx_count_o       requests accepted so far (saturating)

module kda_client_echo_node #(
  parameter int ring_bytes_p = 10,
  parameter int iterations_p = 16,
  parameter int fifo_els_p   = 2
) (
  input  logic                              clk_i,
  input  logic                              async_reset_n_i,
  input  logic                              en_i,
  input  logic                              v_i,
  input  logic [ring_bytes_p*8-1:0]         data_i,
  output logic                              ready_o,
  output logic                              v_o,
  output logic [ring_bytes_p*8-1:0]         data_o,
  input  logic                              yumi_i,
  output logic                              done_o,
  output logic                              err_o,
  output logic [$clog2(iterations_p+1)-1:0] rx_count_o
);

  localparam int W_LP   = ring_bytes_p * 8;
  localparam int CW_LP  = $clog2(iterations_p + 1);
  localparam int PW_LP  = (fifo_els_p > 1) ? $clog2(fifo_els_p) : 1;
  localparam int FCW_LP = $clog2(fifo_els_p + 1);

  localparam logic [CW_LP-1:0]  ITER_C     = CW_LP'(iterations_p);
  localparam logic [FCW_LP-1:0] FIFO_ELS_C = FCW_LP'(fifo_els_p);
  localparam logic [PW_LP-1:0]  PTR_LAST_C = PW_LP'(fifo_els_p - 1);

  typedef enum logic [1:0] {
    IDLE_S  = 2'd0,
    RUN_S   = 2'd1,
    DRAIN_S = 2'd2,
    DONE_S  = 2'd3
  } state_t;

  // Byte-wise increment of the payload; byte 0 passes through untouched.
  function automatic logic [W_LP-1:0] xform(input logic [W_LP-1:0] pkt);
    logic [W_LP-1:0] res;
    res = pkt;
    for (int i = 1; i < ring_bytes_p; i++) begin
      res[i*8 +: 8] = pkt[i*8 +: 8] + 8'd1;
    end
    return res;
  endfunction

  // Pointer advance with wrap, so the depth need not be a power of two.
  function automatic logic [PW_LP-1:0] ptr_inc(input logic [PW_LP-1:0] p);
    return (p == PTR_LAST_C) ? {PW_LP{1'b0}} : p + {{(PW_LP-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_r, state_nxt_s;
  logic [W_LP-1:0]    mem_r [fifo_els_p];
  logic [PW_LP-1:0]   wr_ptr_r, rd_ptr_r;
  logic [FCW_LP-1:0]  fill_r, fill_nxt_s;
  logic [CW_LP-1:0]   rx_count_r, rx_count_nxt_s;
  logic [CW_LP-1:0]   tx_count_r, tx_count_nxt_s;
  logic               full_s, empty_s, enq_s, deq_s;

  assign full_s  = (fill_r == FIFO_ELS_C);
  assign empty_s = (fill_r == {FCW_LP{1'b0}});

  // ready_o depends only on registers, so there is no path from v_i.
  assign ready_o = (state_r == RUN_S) & ~full_s & (rx_count_r < ITER_C);
  assign enq_s   = v_i & ready_o;
  assign deq_s   = yumi_i & ~empty_s;

  assign v_o        = ~empty_s;
  assign data_o     = empty_s ? {W_LP{1'b0}} : mem_r[rd_ptr_r];
  assign done_o     = (state_r == DONE_S);
  assign rx_count_o = rx_count_r;

  // Next occupancy and saturating counters.
  always_comb begin
    fill_nxt_s     = fill_r;
    rx_count_nxt_s = rx_count_r;
    tx_count_nxt_s = tx_count_r;
    case ({enq_s, deq_s})
      2'b10:   fill_nxt_s = fill_r + {{(FCW_LP-1){1'b0}}, 1'b1};
      2'b01:   fill_nxt_s = fill_r - {{(FCW_LP-1){1'b0}}, 1'b1};
      default: fill_nxt_s = fill_r;
    endcase
    if (enq_s && (rx_count_r != ITER_C)) begin
      rx_count_nxt_s = rx_count_r + {{(CW_LP-1){1'b0}}, 1'b1};
    end else begin
      rx_count_nxt_s = rx_count_r;
    end
    if (deq_s && (tx_count_r != ITER_C)) begin
      tx_count_nxt_s = tx_count_r + {{(CW_LP-1){1'b0}}, 1'b1};
    end else begin
      tx_count_nxt_s = tx_count_r;
    end
  end

  // Next-state logic. Transitions look at the post-edge counters so that
  // DRAIN is entered as rx_count reaches the limit and DONE follows the
  // final yumi by one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE_S: begin
        if (en_i) state_nxt_s = RUN_S;
        else      state_nxt_s = IDLE_S;
      end
      RUN_S: begin
        if (rx_count_nxt_s == ITER_C) state_nxt_s = DRAIN_S;
        else if (!en_i)               state_nxt_s = IDLE_S;
        else                          state_nxt_s = RUN_S;
      end
      DRAIN_S: begin
        if ((fill_nxt_s == {FCW_LP{1'b0}}) && (tx_count_nxt_s == ITER_C)) state_nxt_s = DONE_S;
        else                                                              state_nxt_s = DRAIN_S;
      end
      DONE_S:  state_nxt_s = DONE_S;
      default: state_nxt_s = IDLE_S;
    endcase
  end

  // State, pointers, occupancy and counters.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      state_r    <= IDLE_S;
      wr_ptr_r   <= {PW_LP{1'b0}};
      rd_ptr_r   <= {PW_LP{1'b0}};
      fill_r     <= {FCW_LP{1'b0}};
      rx_count_r <= {CW_LP{1'b0}};
      tx_count_r <= {CW_LP{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      fill_r     <= fill_nxt_s;
      rx_count_r <= rx_count_nxt_s;
      tx_count_r <= tx_count_nxt_s;
      if (enq_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
      if (deq_s) rd_ptr_r <= ptr_inc(rd_ptr_r);
    end
  end

  // FIFO storage; stale contents are masked by the empty gate on data_o.
  always_ff @(posedge clk_i) begin
    if (enq_s) mem_r[wr_ptr_r] <= xform(data_i);
  end

`ifdef KDA_CLIENT_SEQ_CHECK_EN
  logic [7:0] exp_seq_r;
  logic       err_r;

  // Expected sequence advances from itself, not from the received byte.
  always_ff @(posedge clk_i or negedge async_reset_n_i) begin
    if (!async_reset_n_i) begin
      exp_seq_r <= 8'd0;
      err_r     <= 1'b0;
    end else if (enq_s) begin
      exp_seq_r <= exp_seq_r + 8'd1;
      err_r     <= err_r | (data_i[7:0] != exp_seq_r);
    end
  end

  assign err_o = err_r;
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_kda_client_echo_node.sv
module tb_kda_client_echo_node;

  localparam int RB    = 10;
  localparam int W     = RB * 8;
  localparam int ITER  = 16;
  localparam int FIFO  = 2;
  localparam int CW    = $clog2(ITER + 1);
`ifdef KDA_CLIENT_SEQ_CHECK_EN
  localparam bit SEQ_CHK = 1'b1;
`else
  localparam bit SEQ_CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_i, v_i, yumi_i;
  logic [W-1:0]  data_i;
  logic          ready_o, v_o, done_o, err_o;
  logic [W-1:0]  data_o;
  logic [CW-1:0] rx_count_o;

  int n_cmp  = 0;
  int n_fail = 0;

  kda_client_echo_node #(
    .ring_bytes_p(RB), .iterations_p(ITER), .fifo_els_p(FIFO)
  ) dut (
    .clk_i(clk), .async_reset_n_i(rst_n), .en_i(en_i),
    .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
    .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i),
    .done_o(done_o), .err_o(err_o), .rx_count_o(rx_count_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_q[$];
  int m_rx, m_tx, m_seq, m_phase; // phase: 0 idle, 1 running, 2 draining, 3 done
  bit m_err, m_xfer, m_pop;

  function automatic logic [W-1:0] m_xform(input logic [W-1:0] p);
    logic [W-1:0] r;
    int b;
    r = p;
    for (int i = 1; i < RB; i++) begin
      b = int'(p[i*8 +: 8]);
      b = (b + 1) % 256;
      r[i*8 +: 8] = 8'(b);
    end
    return r;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 1) && (m_q.size() < FIFO) && (m_rx < ITER);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q.delete();
      m_rx = 0; m_tx = 0; m_seq = 0; m_phase = 0; m_err = 1'b0;
    end else begin
      m_xfer = v_i && m_ready();
      m_pop  = yumi_i && (m_q.size() > 0);
      if (m_pop) begin
        void'(m_q.pop_front());
        if (m_tx < ITER) m_tx++;
      end
      if (m_xfer) begin
        m_q.push_back(m_xform(data_i));
        if (m_rx < ITER) m_rx++;
        if (SEQ_CHK && (int'(data_i[7:0]) != m_seq)) m_err = 1'b1;
        m_seq = (m_seq + 1) % 256;
      end
      case (m_phase)
        0: if (en_i) m_phase = 1;
        1: if (m_rx == ITER) m_phase = 2; else if (!en_i) m_phase = 0;
        2: if (m_q.size() == 0 && m_tx == ITER) m_phase = 3;
        default: ;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ready_o", W'(ready_o), W'(m_ready()));
      check("v_o", W'(v_o), W'(m_q.size() > 0));
      if (m_q.size() > 0) check("data_o", data_o, m_q[0]);
      check("done_o", W'(done_o), W'(m_phase == 3));
      check("err_o", W'(err_o), W'(m_err));
      check("rx_count_o", W'(rx_count_o), W'(m_rx));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic en);
    rst_n = 1'b0; en_i = en; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [W-1:0] pkt(input logic [7:0] seq, input logic [7:0] fill);
    logic [W-1:0] r;
    for (int i = 1; i < RB; i++) r[i*8 +: 8] = fill;
    r[7:0] = seq;
    return r;
  endfunction

  // Offer one request and wait (bounded) until it is accepted.
  task automatic send(input logic [W-1:0] d, output int cycles);
    bit acc;
    v_i = 1'b1; data_i = d; cycles = 0; acc = 1'b0;
    while (!acc && cycles < 20) begin
      acc = m_ready();
      tick();
      cycles++;
    end
    if (!acc) check("accept_timeout", W'(0), W'(1));
  endtask

  initial begin
    int c, total;
    rst_n = 1'b1; en_i = 1'b0; v_i = 1'b0; yumi_i = 1'b0; data_i = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", W'(ready_o), W'(0));
    check("rst_v", W'(v_o), W'(0));
    check("rst_data", data_o, W'(0));
    check("rst_done", W'(done_o), W'(0));
    check("rst_err", W'(err_o), W'(0));
    check("rst_rx", W'(rx_count_o), W'(0));

    // 1: full 16-iteration run with yumi held high
    do_reset(1'b1);
    tick();
    yumi_i = 1'b1; total = 0;
    for (int s = 0; s < ITER; s++) begin
      send(pkt(8'(s), 8'h00), c);
      total += c;
      if (s == 0) check("first_resp", data_o, 80'h01010101010101010100);
    end
    v_i = 1'b0;
    check("throughput", W'(total), W'(ITER));
    check("rx16", W'(rx_count_o), W'(16));
    tick();
    check("done_after_last_yumi", W'(done_o), W'(1));
    check("err_run", W'(err_o), W'(0));
    yumi_i = 1'b0;
    tick();
    check("done_sticky", W'(done_o), W'(1));

    // 2: byte wrap without carry
    do_reset(1'b1);
    tick();
    send(pkt(8'h00, 8'hFF), c);
    v_i = 1'b0;
    check("wrap_v", W'(v_o), W'(1));
    check("wrap_data", data_o, W'(0));
    send(80'hFE807F00FF123456FF01, c);
    v_i = 1'b0;
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    check("mixed_data", data_o, 80'hFF818001001335570001);
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;

    // 3: backpressure with a full FIFO
    do_reset(1'b1);
    tick();
    send(pkt(8'd0, 8'h10), c);
    send(pkt(8'd1, 8'h20), c);
    data_i = pkt(8'd2, 8'h30);
    check("full_ready", W'(ready_o), W'(0));
    yumi_i = 1'b1; tick(); yumi_i = 1'b0;
    check("ready_after_pulse", W'(ready_o), W'(1));
    tick();
    v_i = 1'b0;
    check("order_head", W'(data_o[7:0]), W'(1));
    yumi_i = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    yumi_i = 1'b0;

    // 4: sequence check 0,1,5,3
    do_reset(1'b1);
    tick();
    yumi_i = 1'b1;
    send(pkt(8'd0, 8'h00), c);
    send(pkt(8'd1, 8'h00), c);
    check("err_before", W'(err_o), W'(0));
    send(pkt(8'd5, 8'h00), c);
    check("err_after5", W'(err_o), W'(SEQ_CHK));
    send(pkt(8'd3, 8'h00), c);
    v_i = 1'b0;
    tick(); tick();
    check("err_sticky", W'(err_o), W'(SEQ_CHK));
    yumi_i = 1'b0;

    // 5: asynchronous reset mid-run
    do_reset(1'b1);
    tick();
    yumi_i = 1'b1;
    for (int s = 0; s < 7; s++) send(pkt(8'(s), 8'h00), c);
    v_i = 1'b0; yumi_i = 1'b0;
    check("mid_rx7", W'(rx_count_o), W'(7));
    check("mid_v", W'(v_o), W'(1));
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", W'(ready_o), W'(0));
    check("arst_v", W'(v_o), W'(0));
    check("arst_data", data_o, W'(0));
    check("arst_rx", W'(rx_count_o), W'(0));
    check("arst_done", W'(done_o), W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    send(pkt(8'd0, 8'h00), c);
    v_i = 1'b0;
    check("restart_rx", W'(rx_count_o), W'(1));

    // 6: disabled node ignores requests
    do_reset(1'b0);
    v_i = 1'b1; data_i = pkt(8'd0, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("dis_ready", W'(ready_o), W'(0));
    end
    check("dis_v", W'(v_o), W'(0));
    check("dis_rx", W'(rx_count_o), W'(0));
    v_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/kda_client_echo_node.md
# kda_client_echo_node

Client-side responder for the KDA ring test traffic. It sits on the ASIC end of the link, behind the client channel of `bsg_guts`, and answers the master test node's request packets. Each accepted request is transformed, buffered and returned. The node counts completed round trips, optionally checks request sequence numbers, and raises a sticky done once `iterations_p` responses have been consumed, which lets the gateway's all-done detection terminate simulation.

## Interface
Parameters:
- `ring_bytes_p`, 10: packet width in bytes; packet width is `ring_bytes_p*8` bits.
- `iterations_p`, 16: number of round trips before done; must be ≥1.
- `fifo_els_p`, 2: response buffer depth; must be ≥2.

Ports:
- `clk_i`  in  1  core clock.
- `async_reset_n_i`  in  1  reset, asynchronous, active-low.
- `en_i`  in  1  node enable; sampled each cycle.
- `v_i`  in  1  request valid.
- `data_i`  in  ring_bytes_p*8  request packet; byte 0 is the sequence number.
- `ready_o`  out  1  request accept; a transfer occurs when `v_i & ready_o`.
- `v_o`  out  1  response valid.
- `data_o`  out  ring_bytes_p*8  response packet.
- `yumi_i`  in  1  response consumed; legal only when `v_o=1`.
- `done_o`  out  1  sticky completion.
- `err_o`  out  1  sticky sequence error.
- `rx_count_o`  out  $clog2(iterations_p+1)  requests accepted so far.

## Operation
- States:
  - IDLE: after reset. Goes to RUN when `en_i=1`.
  - RUN: accepts requests. Goes to DRAIN on the cycle `rx_count` reaches `iterations_p`. If `en_i` drops, returns to IDLE; FIFO contents and counters are retained.
  - DRAIN: accepts no requests. Goes to DONE when the FIFO is empty and the tx count equals `iterations_p`.
  - DONE: terminal until reset. `done_o=1`.
- `ready_o = (state==RUN) & ~fifo_full & (rx_count < iterations_p)`. It is a function of registered state only and has no combinational path from `v_i`.
- Transform, applied on enqueue:
  - Byte 0 is echoed unchanged.
  - Bytes 1..ring_bytes_p-1 each become `(byte+1) mod 256`, wrapping 8'hFF→8'h00 with no carry into the neighbouring byte.
- FIFO: `fifo_els_p` entries, first-in first-out. `v_o = ~fifo_empty`; `data_o` = head entry.
- Enqueue and dequeue in the same cycle are allowed when the FIFO is not full. Occupancy is then unchanged.
- When full, `ready_o=0` even if `yumi_i=1` that cycle; there is no full-bypass.
- Counters:
  - `rx_count` increments on each request transfer.
  - An internal tx count increments on each `yumi_i`.
  - Both saturate at `iterations_p`.
- A `yumi_i` with `v_o=0` is ignored and counts nothing.
- Reset asserted mid-operation clears the FIFO, counters, sticky flags and state immediately. Responses in flight are lost.

## Timing
- Reset values: `ready_o=0`, `v_o=0`, `data_o=0`, `done_o=0`, `err_o=0`, `rx_count_o=0`.
- First `ready_o=1` occurs in the cycle after the cycle in which IDLE samples `en_i=1`.
- Latency: a request accepted in cycle N gives `v_o=1` with the transformed data in cycle N+1 if the FIFO was empty.
- Sustained throughput is one packet per cycle when `yumi_i` is held high.
- `done_o` rises one cycle after the final `yumi_i` when the FIFO is then empty.
- `err_o` rises in the cycle after the offending request is accepted.

## Configuration
- Macro: `KDA_CLIENT_SEQ_CHECK_EN`.
- Defined:
  - An expected sequence register, reset 0, increments mod 256 on each accepted request.
  - A request whose byte 0 ≠ expected sets `err_o`, which stays set until reset.
  - The expected value still advances from the expected value, not from the received byte.
  - The packet is still echoed normally.
- Undefined: no sequence register; `err_o` is tied 0.

## Test plan
- Reset with `en_i=1` and `iterations_p=16`; send 16 requests with seq 0..15 and payload bytes all 8'h00; hold `yumi_i=1` → each response has byte0 = seq and all other bytes 8'h01; `rx_count_o` reaches 16; `done_o=1` one cycle after the 16th yumi; `err_o=0`.
- Payload bytes 8'hFF, seq 8'h00 → response payload bytes are 8'h00 and byte 0 is 8'h00; no carry between bytes.
- Hold `yumi_i=0` and offer 3 requests → first two accepted, `ready_o=0` on the third; pulse `yumi_i` once → `ready_o=1` the next cycle and the third request is accepted in order.
- With `KDA_CLIENT_SEQ_CHECK_EN` defined, send seq 0, 1, 5, 3 → `err_o` rises after seq 5 and stays 1; all four are echoed. With the macro undefined, the same stimulus leaves `err_o=0`.
- Assert `async_reset_n_i=0` mid-run with 1 entry buffered and `rx_count_o=7` → all outputs return to reset values immediately without a clock edge; after release and `en_i`, the count restarts from 0.
- Hold `en_i=0` with `v_i=1` → `ready_o` stays 0 indefinitely; `v_o=0`; no counts change.
